// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory and the IF/ID register.
// Optional macro DELAY_SLOT_EN selects branch-delay-slot redirect semantics.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h44000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IFo,
    output logic [31:0] Instruction_IFo,
    output logic        valid_IFo
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [1:0]  state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] target, target_n;
    logic [31:0] hold_word, hold_word_n;
    logic [31:0] hold_pc, hold_pc_n;
    logic [31:0] hold_next, hold_next_n;
    logic        load, bubble;
    logic [31:0] load_word, load_pc;
    logic [31:0] pc4, rpc;

    // Request drops with reset itself, not at the next edge.
    assign imem_req  = ((state == S_REQ) || (state == S_DISCARD)) && !reset;
    assign imem_addr = fetch_pc;
    assign pc4       = fetch_pc + 32'd4;
    assign rpc       = redirect_pc & ~32'd3;

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        target_n    = target;
        hold_word_n = hold_word;
        hold_pc_n   = hold_pc;
        hold_next_n = hold_next;
        load        = 1'b0;
        bubble      = 1'b0;
        load_word   = '0;
        load_pc     = '0;

        case (state)
            S_IDLE: begin
                state_n = S_REQ;
                if (redirect) fetch_pc_n = rpc;
                bubble = redirect || !stall;
            end
            S_REQ: begin
                if (redirect) begin
                    if (imem_ready) begin
`ifdef DELAY_SLOT_EN
                        load      = 1'b1;
                        load_word = imem_rdata;
                        load_pc   = pc4;
`else
                        bubble    = 1'b1;
`endif
                        fetch_pc_n = rpc;
                    end else begin
                        target_n = rpc;
                        state_n  = S_DISCARD;
                        bubble   = 1'b1;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        hold_word_n = imem_rdata;
                        hold_pc_n   = pc4;
                        hold_next_n = pc4;
                        state_n     = S_HOLD;
                    end else begin
                        load       = 1'b1;
                        load_word  = imem_rdata;
                        load_pc    = pc4;
                        fetch_pc_n = pc4;
                    end
                end else begin
                    bubble = !stall;
                end
            end
            S_HOLD: begin
                if (redirect) begin
`ifdef DELAY_SLOT_EN
                    load      = 1'b1;
                    load_word = hold_word;
                    load_pc   = hold_pc;
`else
                    bubble    = 1'b1;
`endif
                    fetch_pc_n = rpc;
                    state_n    = S_REQ;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_word  = hold_word;
                    load_pc    = hold_pc;
                    fetch_pc_n = hold_next;
                    state_n    = S_REQ;
                end
            end
            S_DISCARD: begin
                if (imem_ready) begin
`ifdef DELAY_SLOT_EN
                    // A stalled delay-slot word parks in HOLD with the target as its successor.
                    if (stall && !redirect) begin
                        hold_word_n = imem_rdata;
                        hold_pc_n   = pc4;
                        hold_next_n = target;
                        state_n     = S_HOLD;
                    end else begin
                        load       = 1'b1;
                        load_word  = imem_rdata;
                        load_pc    = pc4;
                        fetch_pc_n = redirect ? rpc : target;
                        state_n    = S_REQ;
                    end
`else
                    fetch_pc_n = redirect ? rpc : target;
                    state_n    = S_REQ;
                    bubble     = redirect || !stall;
`endif
                end else begin
                    if (redirect) target_n = rpc;
                    bubble = redirect || !stall;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            fetch_pc        <= RESET_PC;
            target          <= '0;
            hold_word       <= '0;
            hold_pc         <= '0;
            hold_next       <= '0;
            PC_IFo          <= '0;
            Instruction_IFo <= NOP_WORD;
            valid_IFo       <= 1'b0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            target    <= target_n;
            hold_word <= hold_word_n;
            hold_pc   <= hold_pc_n;
            hold_next <= hold_next_n;
            if (load) begin
                Instruction_IFo <= load_word;
                PC_IFo          <= load_pc;
                valid_IFo       <= 1'b1;
            end else if (bubble) begin
                Instruction_IFo <= NOP_WORD;
                valid_IFo       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected deliveries are queued by the
// stimulus and popped by a monitor whenever a new valid word appears.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h44000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic [31:0] PC_IFo;
    logic [31:0] Instruction_IFo;
    logic        valid_IFo;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [63:0] exp_q[$];
    logic        frozen_q = 1'b1;

    fetch_unit #(.RESET_PC(32'h00000000), .NOP_WORD(32'h44000000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_IFo(PC_IFo),
        .Instruction_IFo(Instruction_IFo), .valid_IFo(valid_IFo)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h10) ? 32'h8C010000 : (a ^ 32'h5A5A0000);
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word);
        exp_q.push_back({pc, word});
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Outputs may only change on an edge where stall was low or redirect was high.
    always @(posedge clk) frozen_q <= reset || (stall && !redirect);

    always @(negedge clk) begin
        if (!reset && !frozen_q && valid_IFo) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got pc %08h instr %08h expected none", PC_IFo, Instruction_IFo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("deliver_pc", PC_IFo, e[63:32]);
                check("deliver_instr", Instruction_IFo, e[31:0]);
            end
        end
    end

    initial begin
        @(negedge clk);
        check("rst_pc", PC_IFo, 32'h0);
        check("rst_instr", Instruction_IFo, NOP);
        check("rst_valid", {31'b0, valid_IFo}, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        reset = 1'b0;
        cyc();
        check("idle_to_req", {31'b0, imem_req}, 32'h1);

        // Zero-wait streaming up to 0x10
        for (int unsigned a = 0; a < 32'h10; a += 4) begin
            check("stream_addr", imem_addr, a);
            push(a + 4, mem(a));
            cyc();
        end

        // Three wait cycles on 0x10
        imem_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            cyc();
            check("wait_instr", Instruction_IFo, NOP);
            check("wait_valid", {31'b0, valid_IFo}, 32'h0);
            check("wait_addr", imem_addr, 32'h10);
        end
        imem_ready = 1'b1;
        push(32'h14, 32'h8C010000);
        cyc();
        for (int unsigned a = 32'h14; a < 32'h20; a += 4) begin
            push(a + 4, mem(a));
            cyc();
        end
        check("pre_stall_addr", imem_addr, 32'h20);

        // Stall at completion of 0x20 for two cycles
        stall = 1'b1;
        cyc();
        check("hold_req", {31'b0, imem_req}, 32'h0);
        check("hold_pc", PC_IFo, 32'h20);
        cyc();
        check("hold_req2", {31'b0, imem_req}, 32'h0);
        check("hold_instr", Instruction_IFo, mem(32'h1C));
        stall = 1'b0;
        push(32'h24, mem(32'h20));
        cyc();
        check("post_hold_addr", imem_addr, 32'h24);
        for (int unsigned a = 32'h24; a < 32'h40; a += 4) begin
            push(a + 4, mem(a));
            cyc();
        end

        // Redirect to 0x100 while 0x40 waits; low bits of the target ignored
        imem_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        cyc();
        redirect = 1'b0;
        check("discard_req", {31'b0, imem_req}, 32'h1);
        check("discard_addr", imem_addr, 32'h40);
        check("discard_valid", {31'b0, valid_IFo}, 32'h0);
        cyc();
        check("discard_addr2", imem_addr, 32'h40);
        imem_ready = 1'b1;
`ifdef DELAY_SLOT_EN
        push(32'h44, mem(32'h40));
`endif
        cyc();
`ifndef DELAY_SLOT_EN
        check("discard_drop_valid", {31'b0, valid_IFo}, 32'h0);
`endif
        check("redirect_addr", imem_addr, 32'h100);
        push(32'h104, mem(32'h100));
        cyc();

        // Redirect coinciding with completion of 0x104
        redirect = 1'b1;
        redirect_pc = 32'h200;
`ifdef DELAY_SLOT_EN
        push(32'h108, mem(32'h104));
`endif
        cyc();
`ifndef DELAY_SLOT_EN
        check("coinc_valid", {31'b0, valid_IFo}, 32'h0);
`endif
        check("coinc_addr", imem_addr, 32'h200);

        // Redirect to the top word, then wrap
        redirect_pc = 32'hFFFFFFFC;
`ifdef DELAY_SLOT_EN
        push(32'h204, mem(32'h200));
`endif
        cyc();
        redirect = 1'b0;
        check("top_addr", imem_addr, 32'hFFFFFFFC);
        push(32'h0, mem(32'hFFFFFFFC));
        cyc();
        check("wrap_addr", imem_addr, 32'h0);

        // Redirect while holding a stalled word
        stall = 1'b1;
        cyc();
        check("hold2_req", {31'b0, imem_req}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h300;
`ifdef DELAY_SLOT_EN
        push(32'h4, mem(32'h0));
`endif
        cyc();
        redirect = 1'b0;
        stall = 1'b0;
`ifndef DELAY_SLOT_EN
        check("hold_redir_instr", Instruction_IFo, NOP);
        check("hold_redir_valid", {31'b0, valid_IFo}, 32'h0);
`endif
        check("hold_redir_addr", imem_addr, 32'h300);

        // Reset in the middle of a wait
        imem_ready = 1'b0;
        cyc();
        check("midwait_req", {31'b0, imem_req}, 32'h1);
        reset = 1'b1;
        #1;
        check("async_req", {31'b0, imem_req}, 32'h0);
        check("async_valid", {31'b0, valid_IFo}, 32'h0);
        check("async_instr", Instruction_IFo, NOP);
        @(negedge clk);
        reset = 1'b0;
        imem_ready = 1'b1;
        cyc();
        check("rerst_addr", imem_addr, 32'h0);
        check("rerst_req", {31'b0, imem_req}, 32'h1);
        stall = 1'b1;
        cyc();
        cyc();

        check("queue_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_WORD, default 32'h44000000 (opcode 6'h11), SHALL be the bubble instruction driven to IF/ID.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard hold; IF/ID outputs SHALL stay frozen while high.
REQ-006 redirect  input  1  branch/jump taken, one-cycle pulse from ID.
REQ-007 redirect_pc  input  32  target address; bits [1:0] SHALL be ignored and treated as 2'b00.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  word address of the current request.
REQ-010 imem_ready  input  1  memory completion strobe; imem_rdata valid in the same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 PC_IFo  output  32  fetch address + 4, fed to the IF/ID PC input.
REQ-013 Instruction_IFo  output  32  instruction fed to the IF/ID instruction input.
REQ-014 valid_IFo  output  1  high when Instruction_IFo is a real fetched word, not a bubble.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, HOLD and DISCARD; imem_req SHALL be high only in REQ and DISCARD.
REQ-016 imem_addr SHALL equal internal fetch_pc and SHALL stay stable while imem_req is high and imem_ready is low.
REQ-017 A fetch completes on any edge where imem_req and imem_ready are both high.
REQ-018 Completion in REQ with stall=0 and redirect=0 SHALL load Instruction_IFo<=imem_rdata, PC_IFo<=fetch_pc+4, valid_IFo<=1 and fetch_pc<=fetch_pc+4, with the FSM staying in REQ; a zero-wait memory therefore gives 1 instruction/cycle.
REQ-019 Completion in REQ with stall=1 SHALL store the word and its PC in a hold register, go to HOLD, and leave the outputs unchanged.
REQ-020 In HOLD, imem_req SHALL be 0; when stall=0 the held word SHALL be presented with valid_IFo=1, fetch_pc SHALL advance by 4, and the FSM SHALL go to REQ.
REQ-021 With no completion and stall=0, Instruction_IFo SHALL become NOP_WORD, valid_IFo SHALL become 0, and PC_IFo SHALL hold.
REQ-022 With stall=1 and no completion, all IF/ID outputs SHALL hold.
REQ-023 redirect SHALL take priority over stall.
REQ-024 Redirect with a request pending and not completing SHALL latch the target and go to DISCARD; on the next completion the data SHALL be dropped, fetch_pc SHALL be set to the target, and the FSM SHALL go to REQ.
REQ-025 Redirect in HOLD or in REQ without a pending request SHALL drop any held word, set fetch_pc to redirect_pc, output NOP_WORD with valid_IFo=0, and go to REQ.
REQ-026 Redirect coinciding with a completion SHALL drop the word (see REQ-035 for the alternative), set fetch_pc to redirect_pc, and go to REQ.
REQ-027 A redirect received in DISCARD SHALL overwrite the latched target.
REQ-028 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).

Reset
REQ-029 Reset SHALL force PC_IFo=0, Instruction_IFo=NOP_WORD, valid_IFo=0, imem_req=0, fetch_pc=RESET_PC and state IDLE.
REQ-030 imem_req SHALL drop combinationally when reset asserts, so an outstanding fetch is abandoned.
REQ-031 IDLE SHALL go to REQ on the first clock edge after reset deasserts.

Configuration
REQ-032 The macro DELAY_SLOT_EN SHALL select MIPS branch-delay-slot semantics.
REQ-033 Undefined: redirect squashes the in-flight or held instruction (REQ-024 to REQ-026).
REQ-034 Defined, DISCARD: the in-flight word SHALL be delivered, not dropped, and fetch SHALL then continue at the latched target.
REQ-035 Defined, HOLD or coinciding completion: the held or completing word SHALL be delivered, and the next fetch_pc SHALL be the target.

Verification
REQ-036 Reset, zero-wait memory (ready=1), RESET_PC=0 -> imem_addr 0,4,8 on consecutive cycles; PC_IFo 4,8,12; valid_IFo=1 each cycle.
REQ-037 ready low 3 cycles for addr 0x10, stall=0 -> NOP_WORD with valid=0 for 3 cycles; then rdata 0x8C010000 appears with PC_IFo=0x14.
REQ-038 stall=1 for 2 cycles at completion of addr 0x20 -> outputs frozen and imem_req=0; after release the word appears with PC_IFo=0x24.
REQ-039 redirect to 0x100 while fetch of 0x40 is pending -> DISCARD; next imem_addr 0x100; 0x40 word never valid (macro undefined) or delivered once (macro defined).
REQ-040 fetch_pc=0xFFFFFFFC completes -> PC_IFo=0x00000000 and next imem_addr=0x00000000.
REQ-041 reset asserted mid-wait -> imem_req=0 immediately; after release imem_addr=RESET_PC.
